// File: rtl/lut_ram_gamma.sv
// Two-bank gamma LUT on a valid/ready pixel stream. Lookups read the active
// bank; host writes go to the shadow bank, which becomes active at the next SOF after a commit.
module lut_ram_gamma #(
  parameter int PX_WIDTH  = 10,
  parameter int LUT_DEPTH = 2**PX_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                s_tvalid_i,
  output logic                s_tready_o,
  input  logic [PX_WIDTH-1:0] s_tdata_i,
  input  logic                s_tuser_i,
  input  logic                s_tlast_i,
  output logic                m_tvalid_o,
  output logic [PX_WIDTH-1:0] m_tdata_o,
  output logic                m_tuser_o,
  output logic                m_tlast_o,
  input  logic                m_tready_i,
  input  logic                lut_wr_i,
  input  logic [PX_WIDTH-1:0] lut_addr_i,
  input  logic [PX_WIDTH-1:0] lut_data_i,
  input  logic                lut_commit_i,
  output logic                lut_pending_o,
  output logic                active_bank_o
);

  logic [PX_WIDTH-1:0] bank0 [LUT_DEPTH];
  logic [PX_WIDTH-1:0] bank1 [LUT_DEPTH];

  logic                en, acc, swap, rd_sel, wr_sel;
  logic                bank_q, bank_d, pend_q, pend_d;
  logic                v1_q, u1_q, l1_q, sel1_q;
  logic [PX_WIDTH-1:0] rd0_q, rd1_q;
  logic                mv_q, mu_q, ml_q;
  logic [PX_WIDTH-1:0] md_q;

  assign en     = !mv_q || m_tready_i;
  assign acc    = s_tvalid_i && en;
  assign swap   = acc && s_tuser_i && pend_q;
  // The swapping SOF already reads the new bank; a write in that same cycle
  // lands in the bank that just became shadow.
  assign rd_sel = bank_q ^ swap;
  assign wr_sel = ~rd_sel;

  always_comb begin
    bank_d = bank_q;
    pend_d = pend_q;
    if (swap) begin
      bank_d = ~bank_q;
      pend_d = 1'b0;
    end else if (lut_commit_i) begin
      pend_d = 1'b1;
    end
  end

  // LUT storage has no reset so tables survive rst_i.
  always_ff @(posedge clk_i) begin
    if (lut_wr_i && !wr_sel) bank0[lut_addr_i] <= lut_data_i;
    if (lut_wr_i &&  wr_sel) bank1[lut_addr_i] <= lut_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (en) begin
      rd0_q <= bank0[s_tdata_i];
      rd1_q <= bank1[s_tdata_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_q <= 1'b0;
      pend_q <= 1'b0;
      v1_q   <= 1'b0;
      u1_q   <= 1'b0;
      l1_q   <= 1'b0;
      sel1_q <= 1'b0;
      mv_q   <= 1'b0;
      md_q   <= '0;
      mu_q   <= 1'b0;
      ml_q   <= 1'b0;
    end else begin
      bank_q <= bank_d;
      pend_q <= pend_d;
      if (en) begin
        v1_q   <= s_tvalid_i;
        u1_q   <= s_tuser_i;
        l1_q   <= s_tlast_i;
        sel1_q <= rd_sel;
        mv_q   <= v1_q;
        md_q   <= sel1_q ? rd1_q : rd0_q;
        mu_q   <= u1_q;
        ml_q   <= l1_q;
      end
    end
  end

  assign s_tready_o    = en;
  assign m_tvalid_o    = mv_q;
  assign m_tdata_o     = md_q;
  assign m_tuser_o     = mu_q;
  assign m_tlast_o     = ml_q;
  assign lut_pending_o = pend_q;
  assign active_bank_o = bank_q;

endmodule

// File: doc/lut_ram_gamma.md
LUT_RAM_GAMMA -- requirements
Module: lut_ram_gamma

Interface
REQ-001 SHALL have parameter PX_WIDTH, default 10, pixel and LUT word width in bits.
REQ-002 SHALL have parameter LUT_DEPTH, default 2**PX_WIDTH (1024), number of entries per bank.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port s_tvalid_i  input  1  input pixel valid.
REQ-006 SHALL have port s_tready_o  output  1  input pixel accepted when high with s_tvalid_i.
REQ-007 SHALL have port s_tdata_i  input  PX_WIDTH  input pixel; used as LUT address.
REQ-008 SHALL have port s_tuser_i  input  1  start of frame (SOF) marker.
REQ-009 SHALL have port s_tlast_i  input  1  end of line marker.
REQ-010 SHALL have ports m_tvalid_o, m_tdata_o (PX_WIDTH), m_tuser_o, m_tlast_o  output  corrected pixel stream.
REQ-011 SHALL have port m_tready_i  input  1  downstream ready.
REQ-012 SHALL have port lut_wr_i  input  1  write strobe to shadow bank.
REQ-013 SHALL have port lut_addr_i  input  PX_WIDTH  write address.
REQ-014 SHALL have port lut_data_i  input  PX_WIDTH  write data.
REQ-015 SHALL have port lut_commit_i  input  1  single-cycle request to swap banks at next SOF.
REQ-016 SHALL have port lut_pending_o  output  1  commit requested, swap not yet done.
REQ-017 SHALL have port active_bank_o  output  1  index of bank used for lookup.

Function
REQ-018 SHALL hold two LUT banks of LUT_DEPTH x PX_WIDTH; lookup reads active bank, writes go to the other (shadow) bank only.
REQ-019 SHALL write lut_data_i to shadow[lut_addr_i] on every cycle lut_wr_i=1, independent of stream state, pending state and stalls.
REQ-020 SHALL set lut_pending_o on lut_commit_i=1; commit while already pending has no further effect.
REQ-021 SHALL swap banks (toggle active_bank_o, clear lut_pending_o) in the cycle a beat with s_tuser_i=1 is accepted while pending; that SOF beat and all later beats use the new bank.
REQ-022 SHALL never swap mid-frame; without pending, SOF beats cause no change.
REQ-023 SHALL, when lut_commit_i and an accepted SOF coincide with pending=0, set pending only; swap waits for the following SOF.
REQ-024 SHALL output m_tdata_o = active_bank[s_tdata_i] with latency exactly 2 cycles from acceptance when m_tready_i stays high (stage 1 RAM read, stage 2 output register).
REQ-025 SHALL carry tuser and tlast through the same 2 stages, aligned with their pixel.
REQ-026 SHALL stall the whole pipeline with enable en = !m_tvalid_o || m_tready_i; s_tready_o = en; RAM read and all stage registers update only when en=1.
REQ-027 SHALL hold m_tvalid_o, m_tdata_o, m_tuser_o, m_tlast_o stable while m_tvalid_o=1 and m_tready_i=0.
REQ-028 SHALL sustain one pixel per cycle with continuous valid/ready; no bubbles inserted.
REQ-029 SHALL give write-after-read on the shadow bank no visibility to lookups until swap; a write in the same cycle as the swap lands in the bank that becomes shadow after the swap (the old active bank).

Reset
REQ-030 SHALL, on rst_i=1, clear m_tvalid_o, m_tuser_o, m_tlast_o, m_tdata_o to 0, internal stage valids to 0, lut_pending_o to 0, active_bank_o to 0.
REQ-031 SHALL not clear LUT contents on reset; tables survive reset.
REQ-032 SHALL drop in-flight pixels and any pending commit when reset is asserted mid-frame; s_tready_o=1 first cycle after reset release.

Verification
REQ-033 Load shadow with identity, commit, send SOF then pixels 0,5,1023 -> outputs 0,5,1023 each 2 cycles after acceptance, tuser on first, active_bank_o=1.
REQ-034 Load shadow with inverted table (v -> 1023-v), commit mid-frame, send remaining line pixels 7,8 -> still old-table values; next SOF pixel 7 -> 1016, lut_pending_o falls same cycle.
REQ-035 Continuous stream of 64 pixels with m_tready_i toggling 1010... -> every pixel delivered once, in order, no data change while stalled, s_tready_o tracks en.
REQ-036 Commit twice before SOF -> single swap (active_bank_o toggles once); commit coinciding with SOF at pending=0 -> swap only on following SOF.
REQ-037 Assert rst_i for 1 cycle mid-frame with 2 pixels in flight -> m_tvalid_o=0 next cycle, pending cleared, active_bank_o=0, LUT contents unchanged on later reads.
